// File: rtl/corr_pkg.sv
// Shared types and sizing helpers for the correlation sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package corr_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      ACQ  = 2'd2
   } state_t;

   // Total pattern length in bits.
   function automatic int pat_len(input int nm, input int osf);
      return nm * osf;
   endfunction

   // Counter width for a modulus; a modulus of 1 still needs one bit.
   function automatic int cnt_w(input int modulus);
      return (modulus <= 1) ? 1 : $clog2(modulus);
   endfunction

endpackage

// File: rtl/mod_counter.sv
// Modulo-MOD up counter with enable, sync clear and terminal-count flag.
// Latency: count updates on the edge after i_en/i_clr; o_tc is combinational from the count.
// Backpressure: none; counts only when enabled, holds otherwise.
// Ports: i_clk, i_reset (sync, active-high), i_clr (sync clear, beats i_en),
//        i_en (advance by one, wraps at MOD-1), o_tc (count == MOD-1).
module mod_counter
   import corr_pkg::*;
#(
   parameter int MOD = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_en,
   output logic o_tc
);

   localparam int W = cnt_w(MOD);

   logic [W-1:0] r_count;
   logic         w_tc;

   assign w_tc = (r_count == W'(MOD - 1));
   assign o_tc = w_tc;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= w_tc ? '0 : r_count + W'(1);
      end
   end

endmodule

// File: rtl/correlation_sequencer.sv
// Control FSM for the bitstream correlator: loads the pattern, streams samples,
// pulses the result latch every OSF sample shifts and holds Flag for FLAG_LEN cycles.
// Latency: shift enables are combinational with Bit_Valid; Latch/Flag/Pattern_Ready/Busy
// are registered one cycle after the deciding edge. Backpressure: none; Bit_Valid gaps hold all counters.
// Ports: i_clk, i_reset (sync, active-high), i_read (start/restart), i_stop (to idle),
//        i_bit_valid; o_shift_pr, o_shift_sr (combinational), o_latch, o_flag,
//        o_pattern_ready, o_busy (registered).
module correlation_sequencer
   import corr_pkg::*;
#(
   parameter int OSF      = 32,
   parameter int NM       = 128,
   parameter int FLAG_LEN = 4
) (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_read,
   input  logic i_stop,
   input  logic i_bit_valid,
   output logic o_shift_pr,
   output logic o_shift_sr,
   output logic o_latch,
   output logic o_flag,
   output logic o_pattern_ready,
   output logic o_busy
);

   localparam int PAT_LEN = pat_len(NM, OSF);

   state_t r_state;
   logic   r_latch;
   logic   r_flag;
   logic   r_pattern_ready;
   logic   r_busy;

   logic w_ctrl_ok;
   logic w_shift_pr;
   logic w_shift_sr;
   logic w_pat_tc;
   logic w_bit_tc;
   logic w_flag_tc;
   logic w_load_done;
   logic w_latch_due;
   logic w_abort;

   // Any control request suppresses shifting in that cycle: a restart
   // discards the current bit, and Stop/Reset must not disturb the registers.
   assign w_ctrl_ok   = ~i_reset & ~i_stop & ~i_read;
   assign w_shift_pr  = (r_state == LOAD) & i_bit_valid & w_ctrl_ok;
   assign w_shift_sr  = (r_state == ACQ)  & i_bit_valid & w_ctrl_ok;
   assign w_load_done = w_shift_pr & w_pat_tc;
   assign w_latch_due = w_shift_sr & w_bit_tc;
   assign w_abort     = i_read | i_stop;

   assign o_shift_pr      = w_shift_pr;
   assign o_shift_sr      = w_shift_sr;
   assign o_latch         = r_latch;
   assign o_flag          = r_flag;
   assign o_pattern_ready = r_pattern_ready;
   assign o_busy          = r_busy;

   mod_counter #(.MOD(PAT_LEN)) u_pat_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_abort),
      .i_en    (w_shift_pr),
      .o_tc    (w_pat_tc)
   );

   // Cleared on entry to ACQ so every acquisition starts on a symbol boundary.
   mod_counter #(.MOD(OSF)) u_bit_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_abort | w_load_done),
      .i_en    (w_shift_sr),
      .o_tc    (w_bit_tc)
   );

   // Counts the cycles Flag has been high; a new latch restarts the window.
   mod_counter #(.MOD(FLAG_LEN)) u_flag_cnt (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .i_clr   (w_abort | w_latch_due),
      .i_en    (r_flag),
      .o_tc    (w_flag_tc)
   );

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state         <= IDLE;
         r_latch         <= 1'b0;
         r_flag          <= 1'b0;
         r_pattern_ready <= 1'b0;
         r_busy          <= 1'b0;
      end else if (i_stop) begin
         // Pattern_Ready is kept: the loaded pattern is still valid.
         r_state <= IDLE;
         r_latch <= 1'b0;
         r_flag  <= 1'b0;
         r_busy  <= 1'b0;
      end else if (i_read) begin
         r_state         <= LOAD;
         r_latch         <= 1'b0;
         r_flag          <= 1'b0;
         r_pattern_ready <= 1'b0;
         r_busy          <= 1'b1;
      end else begin
         r_latch <= 1'b0;
         unique case (r_state)
            IDLE: begin
               r_busy <= 1'b0;
               r_flag <= 1'b0;
            end
            LOAD: begin
               r_busy <= 1'b1;
               r_flag <= 1'b0;
               if (w_load_done) begin
                  r_state         <= ACQ;
                  r_pattern_ready <= 1'b1;
               end
            end
            ACQ: begin
               r_busy <= 1'b1;
               // Latch one cycle after the OSF-th shift so the combinational
               // correlation sees the updated sample register.
               r_latch <= w_latch_due;
               if (w_latch_due) begin
                  r_flag <= 1'b1;
               end else if (r_flag && w_flag_tc) begin
                  r_flag <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
               r_flag  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_correlation_sequencer.sv
// Directed bench for correlation_sequencer with OSF=4, NM=2, FLAG_LEN=2 (PAT_LEN=8).
// Inputs change 1 time unit after a rising edge; combinational shifts are sampled before
// the next edge, registered outputs 1 time unit after it.
module tb_correlation_sequencer;

   logic clk;
   logic reset, read, stop, bit_valid;
   logic shift_pr, shift_sr, latch, flag, pattern_ready, busy;
   logic s_pr, s_sr;

   int n_checks = 0;
   int n_fail   = 0;

   correlation_sequencer #(.OSF(4), .NM(2), .FLAG_LEN(2)) dut (
      .i_clk           (clk),
      .i_reset         (reset),
      .i_read          (read),
      .i_stop          (stop),
      .i_bit_valid     (bit_valid),
      .o_shift_pr      (shift_pr),
      .o_shift_sr      (shift_sr),
      .o_latch         (latch),
      .o_flag          (flag),
      .o_pattern_ready (pattern_ready),
      .o_busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input int idx, input logic obs, input logic exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s[%0d] observed=%b expected=%b", tag, idx, obs, exp);
      end
   endtask

   // One clock cycle: drive inputs, capture combinational shifts, clock, settle.
   task automatic cyc(input logic rs, input logic rd, input logic st, input logic bv);
      reset     = rs;
      read      = rd;
      stop      = st;
      bit_valid = bv;
      #1;
      s_pr = shift_pr;
      s_sr = shift_sr;
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; read = 1'b0; stop = 1'b0; bit_valid = 1'b0;
      @(posedge clk); #1;

      // Reset state, with Read and Bit_Valid active to show reset wins.
      cyc(1, 1, 0, 1);
      chk("rst_spr", 0, s_pr, 1'b0);
      chk("rst_ssr", 0, s_sr, 1'b0);
      chk("rst_latch", 0, latch, 1'b0);
      chk("rst_flag", 0, flag, 1'b0);
      chk("rst_prdy", 0, pattern_ready, 1'b0);
      chk("rst_busy", 0, busy, 1'b0);

      // Start and load 8 pattern bits.
      cyc(0, 1, 0, 0);
      chk("start_busy", 0, busy, 1'b1);
      chk("start_prdy", 0, pattern_ready, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, 1);
         chk("load_spr", i, s_pr, 1'b1);
         chk("load_ssr", i, s_sr, 1'b0);
         chk("load_busy", i, busy, 1'b1);
         chk("load_prdy", i, pattern_ready, (i == 7));
      end

      // 12 back-to-back samples: latch after shifts 4, 8, 12; flag 2 cycles each.
      for (int i = 0; i < 12; i++) begin
         cyc(0, 0, 0, 1);
         chk("acq_ssr", i, s_sr, 1'b1);
         chk("acq_spr", i, s_pr, 1'b0);
         chk("acq_latch", i, latch, (i % 4 == 3));
         chk("acq_flag", i, flag, (i % 4 == 3) || (i % 4 == 0 && i > 0));
      end
      cyc(0, 0, 0, 0);
      chk("tail_latch", 0, latch, 1'b0);
      chk("tail_flag", 0, flag, 1'b1);
      cyc(0, 0, 0, 0);
      chk("tail_flag", 1, flag, 1'b0);

      // Bit_Valid toggling: only the 4th valid bit (cycle index 6) produces a latch.
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, (i % 2 == 0));
         chk("gap_ssr", i, s_sr, (i % 2 == 0));
         chk("gap_latch", i, latch, (i == 6));
         chk("gap_flag", i, flag, (i == 6) || (i == 7));
      end

      // Read after 2 valid bits in ACQ: back to LOAD, nothing latched.
      cyc(0, 0, 0, 1);
      cyc(0, 0, 0, 1);
      chk("pre_rd_flag", 0, flag, 1'b0);
      cyc(0, 1, 0, 1);
      chk("rd_ssr", 0, s_sr, 1'b0);
      chk("rd_spr", 0, s_pr, 1'b0);
      chk("rd_busy", 0, busy, 1'b1);
      chk("rd_prdy", 0, pattern_ready, 1'b0);
      chk("rd_flag", 0, flag, 1'b0);
      chk("rd_latch", 0, latch, 1'b0);
      // Partial load of 3 bits, then restart inside LOAD.
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 1);
         chk("part_spr", i, s_pr, 1'b1);
         chk("part_latch", i, latch, 1'b0);
      end
      cyc(0, 1, 0, 1);
      chk("restart_spr", 0, s_pr, 1'b0);
      for (int i = 0; i < 8; i++) begin
         cyc(0, 0, 0, 1);
         chk("reload_spr", i, s_pr, 1'b1);
         chk("reload_prdy", i, pattern_ready, (i == 7));
      end

      // Stop and Read together in ACQ: idle, pattern kept, no shifts.
      cyc(0, 0, 0, 1);
      chk("pre_stop_ssr", 0, s_sr, 1'b1);
      cyc(0, 1, 1, 1);
      chk("stop_ssr", 0, s_sr, 1'b0);
      chk("stop_spr", 0, s_pr, 1'b0);
      chk("stop_busy", 0, busy, 1'b0);
      chk("stop_prdy", 0, pattern_ready, 1'b1);
      chk("stop_flag", 0, flag, 1'b0);
      cyc(0, 0, 0, 1);
      chk("idle_ssr", 0, s_sr, 1'b0);
      chk("idle_spr", 0, s_pr, 1'b0);
      chk("idle_busy", 0, busy, 1'b0);
      chk("idle_prdy", 0, pattern_ready, 1'b1);

      // Reset in the cycle a latch is due.
      cyc(0, 1, 0, 0);
      chk("rs_start_prdy", 0, pattern_ready, 1'b0);
      for (int i = 0; i < 8; i++) cyc(0, 0, 0, 1);
      chk("rs_load_prdy", 0, pattern_ready, 1'b1);
      for (int i = 0; i < 3; i++) begin
         cyc(0, 0, 0, 1);
         chk("rs_acq_latch", i, latch, 1'b0);
      end
      cyc(1, 0, 0, 1);
      chk("rs_due_ssr", 0, s_sr, 1'b0);
      chk("rs_due_latch", 0, latch, 1'b0);
      chk("rs_due_flag", 0, flag, 1'b0);
      chk("rs_due_prdy", 0, pattern_ready, 1'b0);
      chk("rs_due_busy", 0, busy, 1'b0);
      cyc(0, 0, 0, 1);
      chk("rs_after_ssr", 0, s_sr, 1'b0);
      chk("rs_after_latch", 0, latch, 1'b0);
      chk("rs_after_busy", 0, busy, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
